split_arb: RTL and testbench

Clocked round-robin arbiter that shares one four-phase (return-to-zero) request/acknowledge channel between N upstream requesters. It sits in front of a `split` fork stage, or any single-channel handshake consumer. It grants one requester at a time, forwards that requester's request as `r_o`, and returns the downstream acknowledge (already joined by the split's C-element) to the granted requester only. It is the synchronous-domain scheduler for the asynchronous flow primitives.

---
 rtl/split_arb_if.sv | 33 +++
 rtl/split_arb.sv | 158 +++++++++++++++
 tb/tb_split_arb.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/split_arb_if.sv
// split_arb_if: handshake bundle between the round-robin arbiter and its
// environment (N upstream requesters plus one shared four-phase channel).
//   master : arbiter view (drives acks, shared request, grant index, busy)
//   slave  : environment view (drives requests and the shared ack)
interface split_arb_if #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0] r_i;
  logic [N-1:0] a_i;
  logic         r_o;
  logic         a_o;
  logic [W-1:0] gnt_o;
  logic         busy_o;

  modport master (
    input  r_i,
    input  a_o,
    output a_i,
    output r_o,
    output gnt_o,
    output busy_o
  );

  modport slave (
    output r_i,
    output a_o,
    input  a_i,
    input  r_o,
    input  gnt_o,
    input  busy_o
  );
endinterface

// File: rtl/split_arb.sv
// split_arb: clocked round-robin arbiter sharing one four-phase
// (return-to-zero) request/acknowledge channel between N requesters.
// The granted requester's request is forwarded as r_o and the channel
// acknowledge a_o is returned only on a_i[gnt].
//
// Build option: define SPLIT_ARB_SYNC_EN to pass r_i and a_o through
// 2-flop synchronizers before the FSM (adds 2 cycles to every edge).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no handshake; arbitrate when any request is up and a_o low
// REQ   | r_o high, waiting for the channel acknowledge
// ACK   | ack returned to the winner, waiting for its request to drop
// RTZ   | r_o low, waiting for the channel acknowledge to drop
module split_arb #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic        clk,
  input  logic        rst,
  split_arb_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    RTZ  = 2'd3
  } state_t;

  state_t       state_q;
  logic [W-1:0] ptr_q;
  logic [W-1:0] gnt_q;
  logic         r_o_q;
  logic [N-1:0] a_i_q;
  logic         busy_q;

  logic [N-1:0] r_smp;
  logic         a_smp;
  logic [W-1:0] pick_d;
  logic [W-1:0] ptr_d;
  logic [N-1:0] gnt_oh_d;

`ifdef SPLIT_ARB_SYNC_EN
  logic [N-1:0] r_s1_q;
  logic [N-1:0] r_s2_q;
  logic         a_s1_q;
  logic         a_s2_q;

  // Two-flop synchronizers for the asynchronous request and ack inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_q <= '0;
      r_s2_q <= '0;
      a_s1_q <= 1'b0;
      a_s2_q <= 1'b0;
    end else begin
      r_s1_q <= bus.r_i;
      r_s2_q <= r_s1_q;
      a_s1_q <= bus.a_o;
      a_s2_q <= a_s1_q;
    end
  end

  assign r_smp = r_s2_q;
  assign a_smp = a_s2_q;
`else
  assign r_smp = bus.r_i;
  assign a_smp = bus.a_o;
`endif

  // Round-robin search: first set request at or after ptr, wrapping at N-1.
  // Scanning from the farthest offset down lets the nearest hit win.
  always_comb begin
    int idx;
    logic [W-1:0] idx_w;
    pick_d = '0;
    idx    = 0;
    idx_w  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx   = (int'(ptr_q) + k) % N;
      idx_w = W'(idx);
      if (r_smp[idx_w]) pick_d = idx_w;
    end
  end

  // Next pointer value once the current grant completes (gnt + 1 mod N)
  always_comb begin
    ptr_d = '0;
    if (gnt_q != W'(N - 1)) ptr_d = gnt_q + 1'b1;
  end

  // One-hot ack pattern for the current grant
  always_comb begin
    gnt_oh_d        = '0;
    gnt_oh_d[gnt_q] = 1'b1;
  end

  // Handshake FSM; every output is a register updated with the state so the
  // outputs depend only on state and the latched grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      r_o_q   <= 1'b0;
      a_i_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A high a_o here means the channel is still returning to zero
          // (for example after a reset mid-handshake); hold off until it drops.
          if ((|r_smp) && !a_smp) begin
            gnt_q   <= pick_d;
            state_q <= REQ;
            r_o_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          // An early drop of the winner's request is not looked at here;
          // ACK notices it on its first sample.
          if (a_smp) begin
            state_q <= ACK;
            a_i_q   <= gnt_oh_d;
          end
        end
        ACK: begin
          if (!r_smp[gnt_q]) begin
            state_q <= RTZ;
            r_o_q   <= 1'b0;
          end
        end
        RTZ: begin
          if (!a_smp) begin
            state_q <= IDLE;
            a_i_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          r_o_q   <= 1'b0;
          a_i_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.r_o    = r_o_q;
  assign bus.a_i    = a_i_q;
  assign bus.gnt_o  = gnt_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_split_arb.sv
// Testbench for split_arb (N=4). Expected grant indices are pushed into a
// scoreboard queue when requests are raised and popped when r_o rises.
// Edge latencies scale with the synchronizer option.
module tb_split_arb;
  localparam int N = 4;
`ifdef SPLIT_ARB_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  localparam int LAT   = 1 + S;
  localparam int BOUND = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;

  split_arb_if #(.N(N)) bus ();

  split_arb #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int exp_q[$];

  task automatic wait_ro(input logic v, output int n);
    n = 0;
    while (bus.r_o !== v && n < BOUND) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ai_hi(output int n);
    n = 0;
    while (bus.a_i === '0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ai_lo(output int n);
    n = 0;
    while (bus.a_i !== '0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One complete handshake served by the bench acting as the channel and
  // as the winning requester. Returns cycles waited for r_o to rise.
  task automatic run_txn(input logic rereq, output int n_req);
    int g;
    int n;
    logic [N-1:0] oh;
    wait_ro(1'b1, n_req);
    checks++;
    if (n_req >= BOUND) $display("FAIL req_timeout: r_o=%b after %0d cycles, want 1", bus.r_o, n_req);
    else passed++;
    g = 0;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty: gnt_o=%0d with no expected grant", bus.gnt_o);
    end else begin
      g = exp_q.pop_front();
      if (bus.gnt_o !== 2'(g)) $display("FAIL gnt_order: gnt_o=%0d want %0d", bus.gnt_o, g);
      else passed++;
    end
    oh = N'(1) << g;
    bus.a_o = 1'b1;
    wait_ai_hi(n);
    checks++;
    if (n !== LAT) $display("FAIL ack_rise_lat: %0d cycles want %0d", n, LAT);
    else passed++;
    checks++;
    if (bus.a_i !== oh) $display("FAIL ack_onehot: a_i=%b want %b", bus.a_i, oh);
    else passed++;
    bus.r_i[g] = 1'b0;
    wait_ro(1'b0, n);
    checks++;
    if (n !== LAT) $display("FAIL req_fall_lat: %0d cycles want %0d", n, LAT);
    else passed++;
    checks++;
    if (bus.gnt_o !== 2'(g)) $display("FAIL gnt_stable: gnt_o=%0d want %0d", bus.gnt_o, g);
    else passed++;
    bus.a_o = 1'b0;
    wait_ai_lo(n);
    checks++;
    if (n !== LAT) $display("FAIL ack_fall_lat: %0d cycles want %0d", n, LAT);
    else passed++;
    checks++;
    if (bus.busy_o !== 1'b0) $display("FAIL busy_idle: busy_o=%b want 0", bus.busy_o);
    else passed++;
    if (rereq) bus.r_i[g] = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.r_i = '0;
    bus.a_o = 1'b0;
    rst     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.r_o !== 1'b0) $display("FAIL rst_r_o: %b want 0", bus.r_o); else passed++;
    checks++;
    if (bus.a_i !== '0) $display("FAIL rst_a_i: %b want 0000", bus.a_i); else passed++;
    checks++;
    if (bus.gnt_o !== '0) $display("FAIL rst_gnt: %0d want 0", bus.gnt_o); else passed++;
    checks++;
    if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: %b want 0", bus.busy_o); else passed++;
    rst = 1'b1;
  endtask

  task automatic test_single();
    int n;
    bus.r_i = 4'b0001;
    exp_q.push_back(0);
    run_txn(1'b0, n);
    checks++;
    if (n !== LAT) $display("FAIL single_req_lat: %0d cycles want %0d", n, LAT); else passed++;
    checks++;
    if (dut.ptr_q !== 2'd1) $display("FAIL single_ptr: ptr=%0d want 1", dut.ptr_q); else passed++;
  endtask

  task automatic test_round_robin();
    int n;
    bus.r_i = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back(i % N);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.r_i = 4'b0001;
      run_txn(i < 3, n);
      checks++;
      if (i == 0) begin
        if (n !== LAT) $display("FAIL rr_first_lat: %0d want %0d", n, LAT); else passed++;
      end else begin
        if (n < 1 || n > LAT) $display("FAIL rr_b2b_lat: %0d want 1..%0d", n, LAT); else passed++;
      end
      if (i == 3) bus.r_i = 4'b0000;
    end
  endtask

  task automatic test_wrap();
    int n;
    // advance ptr from 1 to 3 with a lone request on 2
    bus.r_i = 4'b0100;
    exp_q.push_back(2);
    run_txn(1'b0, n);
    checks++;
    if (dut.ptr_q !== 2'd3) $display("FAIL wrap_ptr: ptr=%0d want 3", dut.ptr_q); else passed++;
    bus.r_i = 4'b0110;
    exp_q.push_back(1);
    exp_q.push_back(2);
    run_txn(1'b0, n);
    run_txn(1'b0, n);
  endtask

  task automatic test_reset_mid();
    int n;
    bus.r_i = 4'b0001;
    exp_q.push_back(0);
    wait_ro(1'b1, n);
    bus.a_o = 1'b1;
    wait_ai_hi(n);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.r_o !== 1'b0 || bus.a_i !== '0) $display("FAIL rstmid_async: r_o=%b a_i=%b want 0/0000", bus.r_o, bus.a_i);
    else passed++;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.gnt_o !== '0) $display("FAIL rstmid_state: busy=%b gnt=%0d want 0/0", bus.busy_o, bus.gnt_o);
    else passed++;
    void'(exp_q.pop_front());
    @(negedge clk);
    bus.r_i = 4'b0100;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.r_o !== 1'b0 || bus.busy_o !== 1'b0) $display("FAIL rstmid_hold: r_o=%b busy=%b want 0/0", bus.r_o, bus.busy_o);
      else passed++;
    end
    exp_q.push_back(2);
    bus.a_o = 1'b0;
    wait_ro(1'b1, n);
    checks++;
    if (n !== LAT) $display("FAIL rstmid_req_lat: %0d want %0d", n, LAT); else passed++;
    run_txn(1'b0, n);
  endtask

  task automatic test_req_violation();
    int n;
    bus.r_i = 4'b0001;
    exp_q.push_back(0);
    wait_ro(1'b1, n);
    checks++;
    if (exp_q.size() == 0 || bus.gnt_o !== 2'(exp_q[0])) $display("FAIL viol_gnt: gnt_o=%0d want 0", bus.gnt_o);
    else passed++;
    void'(exp_q.pop_front());
    bus.r_i[3] = 1'b1;
    @(negedge clk);
    bus.r_i[3] = 1'b0;
    bus.r_i[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.r_o !== 1'b1 || bus.a_i !== '0 || bus.gnt_o !== 2'd0)
        $display("FAIL viol_hold: r_o=%b a_i=%b gnt=%0d want 1/0000/0", bus.r_o, bus.a_i, bus.gnt_o);
      else passed++;
    end
    bus.a_o = 1'b1;
    wait_ai_hi(n);
    checks++;
    if (n !== LAT || bus.a_i !== 4'b0001) $display("FAIL viol_ack: lat=%0d a_i=%b want %0d/0001", n, bus.a_i, LAT);
    else passed++;
    wait_ro(1'b0, n);
    checks++;
    if (n !== 1) $display("FAIL viol_rtz_lat: %0d want 1", n); else passed++;
    bus.a_o = 1'b0;
    wait_ai_lo(n);
    checks++;
    if (n !== LAT || bus.busy_o !== 1'b0) $display("FAIL viol_done: lat=%0d busy=%b want %0d/0", n, bus.busy_o, LAT);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    pulse_reset();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_req_violation();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", passed, checks);
    $fatal(1);
  end
endmodule
